line_pair_reader: RTL and testbench
===================================

Name: line_pair_reader

Overview:
- Read-side controller for the rotating line buffer in the scaler path.
- Walks each output line, drives the buffer read address, and delivers bilinear fractions aligned with the 2x2 neighbourhood data.
- Between output lines it retires consumed input lines with the single-line and double-line read-advance strobes.
- Gated by the buffer fill count; sits on the fast clock, ahead of the interpolator.

Parameters:
- ADDRESS_WIDTH, 8, integer width of the line-buffer address
- FRAC_WIDTH, 8, fractional bits of the x/y accumulators and steps
- DIM_WIDTH, 11, width of the output width and height counters
- FILL_WIDTH, 12, width of the fillCount input
- MIN_FILL, 2, lines that must be buffered before an output line starts

Ports:
- clk_fast  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- start  in  1  frame start pulse; ignored while busy
- xStep  in  ADDRESS_WIDTH+FRAC_WIDTH  input pixels per output pixel (unsigned fixed point); sampled at start
- yStep  in  ADDRESS_WIDTH+FRAC_WIDTH  input lines per output line; sampled at start
- outWidth  in  DIM_WIDTH  output pixels per line; sampled at start
- outHeight  in  DIM_WIDTH  output lines per frame; sampled at start
- fillCount  in  FILL_WIDTH  lines written minus lines read, from the line buffer
- readAddress  out  ADDRESS_WIDTH  buffer read address; the buffer internally also reads readAddress+1
- advanceRead1  out  1  retire one line (one-cycle pulse)
- advanceRead2  out  1  retire two lines (one-cycle pulse)
- xFrac  out  FRAC_WIDTH  horizontal weight aligned with pixValid
- yFrac  out  FRAC_WIDTH  vertical weight aligned with pixValid
- pixValid  out  1  neighbourhood data and weights are valid
- pixReady  in  1  downstream accepts
- lineEnd  out  1  qualifies the last pixel of a line (with pixValid)
- frameDone  out  1  one-cycle pulse after the last pixel is accepted
- busy  out  1  high outside IDLE

Behaviour:
- Reset values: all outputs 0. State IDLE. Accumulators and counters cleared. Reset mid-frame aborts the frame with no advance pulses.
- States: IDLE, WAIT_FILL, LINE, DRAIN, ADVANCE, FINISH.
- IDLE:
  - On start, latch xStep, yStep, outWidth and outHeight; set yAcc=0 and outY=0; go to WAIT_FILL.
  - If start arrives with outWidth==0 or outHeight==0, pulse frameDone on the next cycle and stay in IDLE.
- WAIT_FILL: go to LINE when fillCount >= MIN_FILL. Set xAcc=0 and outX=0.
- LINE issue rule: an issue occurs when (!pixValid || pixReady). On each issue:
  - readAddress <= xAcc integer part.
  - Pipeline registers <= xAcc fraction and yAcc fraction.
  - xAcc += xStep; outX++.
- Latency: pixValid asserts 1 cycle after an issue, matching the registered RAM output.
- Stall: while pixValid && !pixReady, readAddress, fractions, pixValid and lineEnd hold. Data must stay stable.
- Line end: the issue with outX==outWidth-1 sets lineEnd for that pixel, then the state goes to DRAIN.
- DRAIN:
  - Wait until the output register is empty (pixValid==0, or the final accept occurs this cycle).
  - Read-select rotation must not change under a held pixel.
  - Then:
    - if outY==outHeight-1, go to FINISH;
    - otherwise compute yNext=yAcc+yStep, set rem = int(yNext) - int(yAcc), set yAcc=yNext, outY++, and go to ADVANCE.
- ADVANCE, one strobe per cycle, only when fillCount >= amount:
  - rem>=2: pulse advanceRead2, rem-=2.
  - rem==1: pulse advanceRead1, rem=0.
  - rem==0: go to WAIT_FILL.
  - advanceRead1 and advanceRead2 are never high together.
- FINISH: pulse frameDone, then go to IDLE. No advance is issued for the final line.
- Arithmetic: accumulators are ADDRESS_WIDTH+FRAC_WIDTH+1 bits. xAcc integer overflow wraps modulo 2^ADDRESS_WIDTH; keeping within range is the caller's duty.

Optional Feature:
- Macro: LINE_PAIR_READER_UNDERRUN_CNT_EN.
- Defined: adds output underrunCycles [15:0]. It is a saturating count of clk_fast cycles spent in WAIT_FILL or a fill-blocked ADVANCE. It clears on start and on rst.
- Undefined: the port still exists, tied to 0, with no counter logic.

Decomposition:
- Shared package:
  - state enum;
  - fixed-point step typedef of width ADDRESS_WIDTH+FRAC_WIDTH;
  - MIN_FILL default.
- One natural sub-module, line_pair_reader_acc: a step accumulator with load/advance and integer-delta output. Instantiated twice, for x and y.

Test Plan:
- xStep=0x0100, yStep=0x0100, outWidth=4, outHeight=3, fillCount held 8, pixReady=1:
  - readAddress 0,1,2,3 per line;
  - xFrac=yFrac=0;
  - exactly 2 advanceRead1 pulses;
  - frameDone after the 12th accept.
- xStep=0x0080, outWidth=4: issued readAddress 0,0,1,1 with xFrac 0x00,0x80,0x00,0x80.
- yStep=0x0280, outHeight=3:
  - first gap: rem=2, one advanceRead2;
  - second gap: rem=3, advanceRead2 then advanceRead1 on consecutive cycles;
  - yFrac 0x00, 0x80, 0x00.
- pixReady low for 5 cycles mid-line: readAddress, xFrac and pixValid held. No pixel lost or duplicated; the pixel count equals outWidth.
- fillCount=1 after start: stays in WAIT_FILL with no pixValid. Raise fillCount to 2: LINE entered the next cycle. With the macro defined, underrunCycles equals the wait length.
- rst asserted mid-line:
  - all outputs 0 the next cycle, with no advance pulse;
  - a new start runs a clean frame.

Source files
------------

// File: rtl/line_pair_reader_pkg.sv
// line_pair_reader_pkg: shared defaults, state encoding and step type for the line-buffer read controller
package line_pair_reader_pkg;
  localparam int DEF_ADDRESS_WIDTH = 8;
  localparam int DEF_FRAC_WIDTH = 8;
  localparam int DEF_DIM_WIDTH = 11;
  localparam int DEF_FILL_WIDTH = 12;
  localparam int DEF_MIN_FILL = 2;
  typedef enum logic [2:0] {IDLE, WAIT_FILL, LINE, DRAIN, ADVANCE, FINISH} state_t;
  typedef logic [DEF_ADDRESS_WIDTH+DEF_FRAC_WIDTH-1:0] step_t;
endpackage

// File: rtl/line_pair_reader_if.sv
// line_pair_reader_if: frame control, fill status, buffer read and pixel stream signals of the read controller
interface line_pair_reader_if #(
  parameter int AW = 8,
  parameter int FW = 8,
  parameter int DW = 11,
  parameter int CW = 12
);
  logic start;
  logic [AW+FW-1:0] xStep, yStep;
  logic [DW-1:0] outWidth, outHeight;
  logic [CW-1:0] fillCount;
  logic [AW-1:0] readAddress;
  logic advanceRead1, advanceRead2;
  logic [FW-1:0] xFrac, yFrac;
  logic pixValid, pixReady, lineEnd, frameDone, busy;
  logic [15:0] underrunCycles;
  modport master (
    input start, xStep, yStep, outWidth, outHeight, fillCount, pixReady,
    output readAddress, advanceRead1, advanceRead2, xFrac, yFrac, pixValid, lineEnd, frameDone, busy, underrunCycles
  );
  modport slave (
    output start, xStep, yStep, outWidth, outHeight, fillCount, pixReady,
    input readAddress, advanceRead1, advanceRead2, xFrac, yFrac, pixValid, lineEnd, frameDone, busy, underrunCycles
  );
endinterface

// File: rtl/line_pair_reader_acc.sv
// line_pair_reader_acc: fixed-point step accumulator with clear/advance and integer delta of the next step
module line_pair_reader_acc #(
  parameter int AW = 8,
  parameter int FW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_adv,
  input  logic [AW+FW-1:0]  i_step,
  output logic [AW-1:0]     o_int,
  output logic [FW-1:0]     o_frac,
  output logic [AW:0]       o_delta
);
  logic [AW+FW:0] r_acc, w_next;
  assign w_next = r_acc + {1'b0, i_step};
  assign o_int = r_acc[AW+FW-1:FW];
  assign o_frac = r_acc[FW-1:0];
  assign o_delta = w_next[AW+FW:FW] - r_acc[AW+FW:FW];
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_acc <= '0;
    else if (i_adv) r_acc <= w_next;
  end
endmodule

// File: rtl/line_pair_reader.sv
// line_pair_reader: line-buffer read controller; LINE_PAIR_READER_UNDERRUN_CNT_EN adds a fill-underrun cycle counter
module line_pair_reader
  import line_pair_reader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
  parameter int DIM_WIDTH = DEF_DIM_WIDTH,
  parameter int FILL_WIDTH = DEF_FILL_WIDTH,
  parameter int MIN_FILL = DEF_MIN_FILL
) (
  input logic clk_fast,
  input logic rst,
  line_pair_reader_if.master bus
);
  localparam int SW = ADDRESS_WIDTH + FRAC_WIDTH;
  localparam logic [FILL_WIDTH-1:0] FILL_MIN = FILL_WIDTH'(MIN_FILL);
  localparam logic [FILL_WIDTH-1:0] FILL_ONE = FILL_WIDTH'(1);
  localparam logic [FILL_WIDTH-1:0] FILL_TWO = FILL_WIDTH'(2);
  state_t r_state;
  logic [SW-1:0] r_xstep, r_ystep;
  logic [DIM_WIDTH-1:0] r_width, r_height, r_outx, r_outy;
  logic [ADDRESS_WIDTH:0] r_rem;
  logic [ADDRESS_WIDTH-1:0] r_read_address;
  logic [FRAC_WIDTH-1:0] r_xfrac, r_yfrac;
  logic r_pix_valid, r_line_end, r_adv1, r_adv2, r_frame_done;
  logic w_issue, w_empty, w_last_x, w_last_y, w_fill_ok;
  logic [ADDRESS_WIDTH-1:0] w_x_int, w_y_int;
  logic [FRAC_WIDTH-1:0] w_x_frac, w_y_frac;
  logic [ADDRESS_WIDTH:0] w_x_delta, w_y_delta;
  assign w_empty = !r_pix_valid || bus.pixReady;
  assign w_issue = r_state == LINE && w_empty;
  assign w_last_x = r_outx == r_width - DIM_WIDTH'(1);
  assign w_last_y = r_outy == r_height - DIM_WIDTH'(1);
  assign w_fill_ok = bus.fillCount >= FILL_MIN;
  line_pair_reader_acc #(.AW(ADDRESS_WIDTH), .FW(FRAC_WIDTH)) u_x_acc (
    .clk(clk_fast), .rst(rst), .i_clr(r_state == WAIT_FILL), .i_adv(w_issue), .i_step(r_xstep),
    .o_int(w_x_int), .o_frac(w_x_frac), .o_delta(w_x_delta)
  );
  line_pair_reader_acc #(.AW(ADDRESS_WIDTH), .FW(FRAC_WIDTH)) u_y_acc (
    .clk(clk_fast), .rst(rst), .i_clr(r_state == IDLE && bus.start),
    .i_adv(r_state == DRAIN && w_empty && !w_last_y), .i_step(r_ystep),
    .o_int(w_y_int), .o_frac(w_y_frac), .o_delta(w_y_delta)
  );
  always_ff @(posedge clk_fast) begin
    if (rst) begin
      r_state <= IDLE;
      r_xstep <= '0;
      r_ystep <= '0;
      r_width <= '0;
      r_height <= '0;
      r_outx <= '0;
      r_outy <= '0;
      r_rem <= '0;
      r_read_address <= '0;
      r_xfrac <= '0;
      r_yfrac <= '0;
      r_pix_valid <= 1'b0;
      r_line_end <= 1'b0;
      r_adv1 <= 1'b0;
      r_adv2 <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_adv1 <= 1'b0;
      r_adv2 <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          if (bus.outWidth == '0 || bus.outHeight == '0) r_frame_done <= 1'b1;
          else begin
            r_xstep <= bus.xStep;
            r_ystep <= bus.yStep;
            r_width <= bus.outWidth;
            r_height <= bus.outHeight;
            r_outy <= '0;
            r_state <= WAIT_FILL;
          end
        end
        WAIT_FILL: begin
          r_outx <= '0;
          if (w_fill_ok) r_state <= LINE;
        end
        LINE: if (w_issue) begin
          r_read_address <= w_x_int;
          r_xfrac <= w_x_frac;
          r_yfrac <= w_y_frac;
          r_pix_valid <= 1'b1;
          r_line_end <= w_last_x;
          r_outx <= r_outx + DIM_WIDTH'(1);
          if (w_last_x) r_state <= DRAIN;
        end
        // Rotation only happens once the held pixel has left the output register.
        DRAIN: if (w_empty) begin
          r_pix_valid <= 1'b0;
          r_line_end <= 1'b0;
          if (w_last_y) begin
            r_frame_done <= 1'b1;
            r_state <= FINISH;
          end else begin
            r_rem <= w_y_delta;
            r_outy <= r_outy + DIM_WIDTH'(1);
            r_state <= ADVANCE;
          end
        end
        ADVANCE: begin
          if (|r_rem[ADDRESS_WIDTH:1]) begin
            if (bus.fillCount >= FILL_TWO) begin
              r_adv2 <= 1'b1;
              r_rem <= r_rem - (ADDRESS_WIDTH+1)'(2);
            end
          end else if (r_rem[0]) begin
            if (bus.fillCount >= FILL_ONE) begin
              r_adv1 <= 1'b1;
              r_rem <= '0;
            end
          end else r_state <= WAIT_FILL;
        end
        FINISH: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef LINE_PAIR_READER_UNDERRUN_CNT_EN
  logic [15:0] r_underrun;
  logic w_adv_blocked;
  assign w_adv_blocked = r_state == ADVANCE &&
    (|r_rem[ADDRESS_WIDTH:1] ? bus.fillCount < FILL_TWO : r_rem[0] && bus.fillCount < FILL_ONE);
  always_ff @(posedge clk_fast) begin
    if (rst || (r_state == IDLE && bus.start)) r_underrun <= '0;
    else if ((r_state == WAIT_FILL && !w_fill_ok) || w_adv_blocked)
      r_underrun <= r_underrun + (&r_underrun ? 16'd0 : 16'd1);
  end
  assign bus.underrunCycles = r_underrun;
`else
  assign bus.underrunCycles = '0;
`endif
  assign bus.readAddress = r_read_address;
  assign bus.xFrac = r_xfrac;
  assign bus.yFrac = r_yfrac;
  assign bus.pixValid = r_pix_valid;
  assign bus.lineEnd = r_line_end;
  assign bus.advanceRead1 = r_adv1;
  assign bus.advanceRead2 = r_adv2;
  assign bus.frameDone = r_frame_done;
  assign bus.busy = r_state != IDLE;
endmodule

// File: tb/tb_line_pair_reader.sv
// tb_line_pair_reader: scoreboard bench for the line-buffer read controller
module tb_line_pair_reader;
  import line_pair_reader_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  line_pair_reader_if #(.AW(8), .FW(8), .DW(11), .CW(12)) bus ();
  line_pair_reader dut (.clk_fast(clk), .rst(rst), .bus(bus));
  int n_tests = 0, n_fail = 0, n_acc = 0, n_adv1 = 0, n_adv2 = 0, cyc = 0;
  logic [24:0] exp_pix[$];
  int exp_adv[$];
  int adv_cyc[$];
  logic [24:0] mon_exp, mon_got;
  int mon_kind, mon_want;
  always @(negedge clk) begin
    cyc++;
    if (bus.pixValid && bus.pixReady) begin
      n_acc++;
      n_tests++;
      mon_got = {bus.readAddress, bus.xFrac, bus.yFrac, bus.lineEnd};
      if (exp_pix.size() == 0) begin
        n_fail++;
        $display("FAIL extra_pixel got {addr,xf,yf,le}=%h expected none", mon_got);
      end else begin
        mon_exp = exp_pix.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL pixel got {addr,xf,yf,le}=%h expected %h", mon_got, mon_exp);
        end
      end
    end
    if (bus.advanceRead1 || bus.advanceRead2) begin
      n_tests++;
      mon_kind = bus.advanceRead2 ? 2 : 1;
      if (bus.advanceRead1) n_adv1++;
      if (bus.advanceRead2) n_adv2++;
      adv_cyc.push_back(cyc);
      mon_want = exp_adv.size() == 0 ? 0 : exp_adv.pop_front();
      if ((bus.advanceRead1 && bus.advanceRead2) || mon_kind != mon_want) begin
        n_fail++;
        $display("FAIL advance got r1=%b r2=%b expected amount %0d", bus.advanceRead1, bus.advanceRead2, mon_want);
      end
    end
  end

  task automatic push_model(input step_t xs, input step_t ys, input int w, input int h);
    logic [16:0] xa, ya, yn;
    int rem;
    if (w == 0 || h == 0) return;
    ya = '0;
    for (int y = 0; y < h; y++) begin
      xa = '0;
      for (int x = 0; x < w; x++) begin
        exp_pix.push_back({xa[15:8], xa[7:0], ya[7:0], 1'(x == w - 1)});
        xa = xa + {1'b0, xs};
      end
      if (y < h - 1) begin
        yn = ya + {1'b0, ys};
        rem = int'(yn[16:8]) - int'(ya[16:8]);
        if (rem < 0) rem += 512;
        while (rem >= 2) begin
          exp_adv.push_back(2);
          rem -= 2;
        end
        if (rem == 1) exp_adv.push_back(1);
        ya = yn;
      end
    end
  endtask

  task automatic start_frame(input step_t xs, input step_t ys, input int w, input int h);
    @(posedge clk) #1;
    bus.xStep = xs;
    bus.yStep = ys;
    bus.outWidth = 11'(w);
    bus.outHeight = 11'(h);
    bus.start = 1'b1;
    push_model(xs, ys, w, h);
    @(posedge clk) #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (bus.frameDone !== 1'b1 && t < 1000) begin
      @(posedge clk) #1;
      t++;
    end
    n_tests++;
    if (bus.frameDone !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done got frameDone=%b expected 1 within 1000 cycles", name, bus.frameDone);
    end
    n_tests++;
    if (exp_pix.size() != 0 || exp_adv.size() != 0) begin
      n_fail++;
      $display("FAIL %s_leftover got pix=%0d adv=%0d outstanding expected 0", name, exp_pix.size(), exp_adv.size());
    end
    @(posedge clk) #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.frameDone !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle got busy=%b frameDone=%b expected 0 0", name, bus.busy, bus.frameDone);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk) #1;
    n_tests++;
    if ({bus.readAddress, bus.advanceRead1, bus.advanceRead2, bus.xFrac, bus.yFrac, bus.lineEnd, bus.frameDone, bus.underrunCycles} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got addr=%h a1=%b a2=%b xf=%h yf=%h le=%b fd=%b uc=%h expected all 0",
               bus.readAddress, bus.advanceRead1, bus.advanceRead2, bus.xFrac, bus.yFrac, bus.lineEnd, bus.frameDone, bus.underrunCycles);
    end
    n_tests++;
    if (bus.pixValid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got pixValid=%b busy=%b expected 0 0", bus.pixValid, bus.busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_unit_step();
    int a0 = n_acc, r1 = n_adv1, r2 = n_adv2;
    start_frame(16'h0100, 16'h0100, 4, 3);
    wait_done("unit");
    n_tests++;
    if (n_acc - a0 != 12 || n_adv1 - r1 != 2 || n_adv2 - r2 != 0) begin
      n_fail++;
      $display("FAIL unit_counts got acc=%0d adv1=%0d adv2=%0d expected 12 2 0", n_acc - a0, n_adv1 - r1, n_adv2 - r2);
    end
  endtask

  task automatic test_half_step();
    int a0 = n_acc;
    start_frame(16'h0080, 16'h0100, 4, 1);
    wait_done("half");
    n_tests++;
    if (n_acc - a0 != 4) begin
      n_fail++;
      $display("FAIL half_count got %0d pixels expected 4", n_acc - a0);
    end
  endtask

  task automatic test_y_step();
    int r1 = n_adv1, r2 = n_adv2;
    adv_cyc.delete();
    start_frame(16'h0100, 16'h0280, 2, 3);
    wait_done("ystep");
    n_tests++;
    if (n_adv2 - r2 != 2 || n_adv1 - r1 != 1) begin
      n_fail++;
      $display("FAIL ystep_counts got adv2=%0d adv1=%0d expected 2 1", n_adv2 - r2, n_adv1 - r1);
    end
    n_tests++;
    if (adv_cyc.size() != 3 || (adv_cyc.size() == 3 && adv_cyc[2] - adv_cyc[1] != 1)) begin
      n_fail++;
      $display("FAIL ystep_consecutive got %0d pulses, last gap %0d expected 3 pulses, gap 1",
               adv_cyc.size(), adv_cyc.size() == 3 ? adv_cyc[2] - adv_cyc[1] : -1);
    end
  endtask

  task automatic test_stall();
    int a0 = n_acc, t = 0;
    logic [7:0] ra, xf;
    start_frame(16'h0140, 16'h0100, 6, 1);
    while (n_acc < a0 + 2 && t < 200) begin
      @(posedge clk) #1;
      t++;
    end
    bus.pixReady = 1'b0;
    ra = bus.readAddress;
    xf = bus.xFrac;
    repeat (5) begin
      @(posedge clk) #1;
      n_tests++;
      if (bus.readAddress !== ra || bus.xFrac !== xf || bus.pixValid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold got addr=%h xf=%h v=%b expected addr=%h xf=%h v=1", bus.readAddress, bus.xFrac, bus.pixValid, ra, xf);
      end
    end
    bus.pixReady = 1'b1;
    wait_done("stall");
    n_tests++;
    if (n_acc - a0 != 6) begin
      n_fail++;
      $display("FAIL stall_count got %0d pixels expected 6", n_acc - a0);
    end
  endtask

  task automatic test_underrun();
    logic quiet = 1'b1;
    bus.fillCount = 12'd1;
    start_frame(16'h0100, 16'h0100, 2, 2);
    repeat (6) begin
      @(posedge clk) #1;
      if (bus.pixValid !== 1'b0 || bus.busy !== 1'b1) quiet = 1'b0;
    end
    n_tests++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL underrun_wait got output activity while fill=1 expected pixValid=0 busy=1");
    end
    bus.fillCount = 12'd2;
    @(posedge clk) #1;
    n_tests++;
`ifdef LINE_PAIR_READER_UNDERRUN_CNT_EN
    if (bus.pixValid !== 1'b0 || bus.underrunCycles !== 16'd6) begin
      n_fail++;
      $display("FAIL underrun_count got v=%b cycles=%0d expected v=0 cycles=6", bus.pixValid, bus.underrunCycles);
    end
`else
    if (bus.pixValid !== 1'b0 || bus.underrunCycles !== 16'd0) begin
      n_fail++;
      $display("FAIL underrun_count got v=%b cycles=%0d expected v=0 cycles=0", bus.pixValid, bus.underrunCycles);
    end
`endif
    @(posedge clk) #1;
    n_tests++;
    if (bus.pixValid !== 1'b1 || bus.readAddress !== 8'd0) begin
      n_fail++;
      $display("FAIL underrun_line got v=%b addr=%h expected v=1 addr=00", bus.pixValid, bus.readAddress);
    end
    wait_done("underrun");
    bus.fillCount = 12'd8;
  endtask

  task automatic test_reset_mid();
    int a0 = n_acc, t = 0, r1, r2;
    start_frame(16'h0100, 16'h0100, 8, 3);
    while (n_acc < a0 + 3 && t < 200) begin
      @(posedge clk) #1;
      t++;
    end
    rst = 1'b1;
    @(posedge clk) #1;
    n_tests++;
    if ({bus.readAddress, bus.advanceRead1, bus.advanceRead2, bus.xFrac, bus.yFrac, bus.pixValid, bus.lineEnd, bus.frameDone, bus.busy, bus.underrunCycles} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs got addr=%h a1=%b a2=%b v=%b busy=%b expected all 0",
               bus.readAddress, bus.advanceRead1, bus.advanceRead2, bus.pixValid, bus.busy);
    end
    rst = 1'b0;
    exp_pix.delete();
    exp_adv.delete();
    r1 = n_adv1;
    r2 = n_adv2;
    repeat (10) @(posedge clk) #1;
    n_tests++;
    if (n_adv1 != r1 || n_adv2 != r2 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_quiet got adv1=%0d adv2=%0d busy=%b expected 0 0 0", n_adv1 - r1, n_adv2 - r2, bus.busy);
    end
    test_unit_step();
  endtask

  task automatic test_zero_dim();
    start_frame(16'h0100, 16'h0100, 0, 3);
    n_tests++;
    if (bus.frameDone !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done got frameDone=%b busy=%b expected 1 0", bus.frameDone, bus.busy);
    end
    @(posedge clk) #1;
    n_tests++;
    if (bus.frameDone !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_pulse got frameDone=%b expected 0", bus.frameDone);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.xStep = '0;
    bus.yStep = '0;
    bus.outWidth = '0;
    bus.outHeight = '0;
    bus.fillCount = 12'd8;
    bus.pixReady = 1'b1;
    test_reset();
    test_unit_step();
    test_half_step();
    test_y_step();
    test_stall();
    test_underrun();
    test_reset_mid();
    test_zero_dim();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
